// File: rtl/seg7_display_decoder_if.sv
// Display bus between a seven-segment source and the decoder that reads it back.
// The master drives the segment pattern; the slave returns decoded status.
interface seg7_display_decoder_if;
   logic [7:0] seg_in;
   logic [3:0] digit;
   logic       dp_out;
   logic       digit_valid;
   logic       pattern_err;
   logic       seq_err;
   logic       locked;
   logic [7:0] err_count;

   modport master (output seg_in,
                   input  digit, dp_out, digit_valid, pattern_err, seq_err, locked, err_count);
   modport slave  (input  seg_in,
                   output digit, dp_out, digit_valid, pattern_err, seq_err, locked, err_count);
endinterface

// File: rtl/seg7_display_decoder.sv
// Passive reader of a 4-bit counter's seven-segment bus: debounces each pattern,
// decodes it to a hex digit and flags illegal glyphs and count-sequence breaks.
module seg7_display_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   seg7_display_decoder_if.slave bus
);

   localparam logic [7:0] SYNC_RST = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [3:0] SC       = 4'(STABLE_CYCLES);

   typedef enum logic {IDLE, TRACK} state_t;

   logic [7:0] sync1, sync2, sample;
   logic [7:0] cand, acc;
   logic [3:0] run_cnt;
   logic       stable, accept, seg_change, legal;
   logic [3:0] dec_digit;

   state_t     state_q, state_d;
   logic [3:0] digit_q, digit_d;
   logic       dp_q, dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
   logic [7:0] errc_q;

   // {legal, digit}; anything that is not one of the 16 glyphs is illegal
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h10;
         7'h06:   decode = 5'h11;
         7'h5B:   decode = 5'h12;
         7'h4F:   decode = 5'h13;
         7'h66:   decode = 5'h14;
         7'h6D:   decode = 5'h15;
         7'h7D:   decode = 5'h16;
         7'h07:   decode = 5'h17;
         7'h7F:   decode = 5'h18;
         7'h6F:   decode = 5'h19;
         7'h77:   decode = 5'h1A;
         7'h7C:   decode = 5'h1B;
         7'h39:   decode = 5'h1C;
         7'h5E:   decode = 5'h1D;
         7'h79:   decode = 5'h1E;
         7'h71:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= SYNC_RST;
         sync2 <= SYNC_RST;
      end else begin
         sync1 <= bus.seg_in;
         sync2 <= sync1;
      end
   end

   assign sample = ACTIVE_LOW ? ~sync2 : sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand    <= 8'h00;
         run_cnt <= 4'd0;
      end else if (sample != cand) begin
         cand    <= sample;
         run_cnt <= 4'd1;
      end else if (run_cnt != SC) begin
         run_cnt <= run_cnt + 4'd1;
      end
   end

   // Stable on the edge where the run count first reaches SC, so outputs land on that same edge
   assign stable     = (sample != cand) ? (SC == 4'd1) : (run_cnt == SC - 4'd1) && (sample == cand);
   assign accept     = stable && (sample != acc);
   assign seg_change = accept && (sample[6:0] != acc[6:0]);
   assign {legal, dec_digit} = decode(sample[6:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc  <= 8'h00;
         dp_q <= 1'b0;
      end else if (accept) begin
         acc  <= sample;
         dp_q <= sample[7];
      end
   end

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      dv_d    = 1'b0;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
      if (seg_change) begin
         if (!legal) begin
            perr_d  = 1'b1;
            state_d = IDLE;
         end else begin
            dv_d    = 1'b1;
            digit_d = dec_digit;
            state_d = TRACK;
            // 0 is always welcome: it covers the counter being reset
            if (state_q == TRACK && dec_digit != digit_q + 4'd1 && dec_digit != 4'd0)
               serr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         digit_q <= 4'h0;
         dv_q    <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         dv_q    <= dv_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         errc_q <= 8'h00;
      else if ((perr_q || serr_q) && errc_q != 8'hFF)
         errc_q <= errc_q + 8'h01;
   end

   assign bus.digit       = digit_q;
   assign bus.dp_out      = dp_q;
   assign bus.digit_valid = dv_q;
   assign bus.pattern_err = perr_q;
   assign bus.seq_err     = serr_q;
   assign bus.locked      = (state_q == TRACK);
   assign bus.err_count   = errc_q;

endmodule

// File: tb/tb_seg7_display_decoder.sv
// Randomized bench for seg7_display_decoder: stimulus is a list of held patterns,
// expected outputs come from a run-length model of the input timeline.
module tb_seg7_display_decoder;
   localparam int SC = 4;

   typedef struct packed {
      logic       dv, pe, se;
      logic [3:0] dig;
      logic       dp, lk;
      logic [7:0] ec;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] pats[$];
   exp_t       expq[$];
   logic [7:0] last_pat = 8'h00;
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg7_display_decoder_if bus();

   seg7_display_decoder #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic seg(input logic [7:0] p, input int hold);
      for (int i = 0; i < hold; i++) pats.push_back(p);
      last_pat = p;
   endtask

   function automatic int glyph_idx(input logic [6:0] s);
      for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
      return -1;
   endfunction

   // Event rule: a run of identical inputs reaching SC samples is judged
   // two clocks later (synchronizer), against the last accepted pattern.
   task automatic build_model();
      logic [7:0] prev = 8'h00, acc = 8'h00;
      int         run = 99, ec = 0, idx;
      logic [3:0] dg = 4'h0;
      logic       dpv = 1'b0, lk = 1'b0, pulse_err_prev = 1'b0;
      exp_t       e;
      for (int j = 0; j < pats.size() + 2; j++) begin
         e = '0;
         if (pulse_err_prev) ec = (ec == 255) ? 255 : ec + 1;
         if (j >= 2) begin
            if (pats[j-2] != prev) run = 1; else run++;
            prev = pats[j-2];
            if (run == SC && prev != acc) begin
               if (prev[6:0] != acc[6:0]) begin
                  idx = glyph_idx(prev[6:0]);
                  if (idx < 0) begin
                     e.pe = 1'b1;
                     lk   = 1'b0;
                  end else begin
                     e.dv = 1'b1;
                     if (lk && idx != ((int'(dg) + 1) % 16) && idx != 0) e.se = 1'b1;
                     dg = 4'(idx);
                     lk = 1'b1;
                  end
               end
               acc = prev;
               dpv = prev[7];
            end
         end
         e.dig = dg; e.dp = dpv; e.lk = lk; e.ec = 8'(ec);
         pulse_err_prev = e.pe | e.se;
         expq.push_back(e);
      end
   endtask

   initial begin
      logic [3:0] gd;
      logic [7:0] p;
      int         r;
      exp_t       e;

      // directed phases
      seg(8'h3F, 10);
      for (int d = 0; d < 17; d++) seg({1'b0, glyph[d % 16]}, 8);
      seg(8'h06, 8); seg(8'h4F, 8); seg(8'h66, 8);
      seg(8'h5B, 8); seg(8'h55, 8); seg(8'h07, 8);
      // random phase
      gd = 4'h7;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            gd = gd + 4'h1;
            p  = {1'b0, glyph[gd]};
         end else if (r < 7) begin
            gd = 4'($urandom_range(0, 15));
            p  = {1'($urandom_range(0, 1)), glyph[gd]};
         end else if (r < 8) begin
            p = 8'($urandom);
         end else begin
            p = last_pat ^ 8'h80;
         end
         if (p == last_pat) p = p ^ 8'h80;
         seg(p, $urandom_range(1, 10));
      end
      // saturation: minimum-hold illegal/legal pairs
      for (int n = 0; n < 300; n++) begin
         seg(8'h55, SC);
         seg(8'h3F, SC);
      end
      // glitch, then dp-only change
      seg(8'h6D, 8); seg(8'h7F, 3); seg(8'h6D, 8); seg(8'hED, 10);

      build_model();

      bus.seg_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digit", 32'(bus.digit), 32'h0);
      chk("rst_dp", 32'(bus.dp_out), 32'h0);
      chk("rst_dv", 32'(bus.digit_valid), 32'h0);
      chk("rst_perr", 32'(bus.pattern_err), 32'h0);
      chk("rst_serr", 32'(bus.seq_err), 32'h0);
      chk("rst_lock", 32'(bus.locked), 32'h0);
      chk("rst_errc", 32'(bus.err_count), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < expq.size(); i++) begin
         bus.seg_in = (i < pats.size()) ? pats[i] : pats[pats.size() - 1];
         @(posedge clk);
         #1;
         e = expq[i];
         chk($sformatf("dv@%0d", i),    32'(bus.digit_valid), 32'(e.dv));
         chk($sformatf("perr@%0d", i),  32'(bus.pattern_err), 32'(e.pe));
         chk($sformatf("serr@%0d", i),  32'(bus.seq_err),     32'(e.se));
         chk($sformatf("digit@%0d", i), 32'(bus.digit),       32'(e.dig));
         chk($sformatf("dp@%0d", i),    32'(bus.dp_out),      32'(e.dp));
         chk($sformatf("lock@%0d", i),  32'(bus.locked),      32'(e.lk));
         chk($sformatf("errc@%0d", i),  32'(bus.err_count),   32'(e.ec));
      end

      // asynchronous reset mid-cycle must clear outputs without a clock edge
      #2;
      rst = 1'b0;
      #1;
      chk("arst_digit", 32'(bus.digit), 32'h0);
      chk("arst_dp", 32'(bus.dp_out), 32'h0);
      chk("arst_lock", 32'(bus.locked), 32'h0);
      chk("arst_errc", 32'(bus.err_count), 32'h0);
      chk("arst_pulses", 32'({bus.digit_valid, bus.pattern_err, bus.seq_err}), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
